// File: rtl/mov_seq_pkg.sv
// Shared encodings for the move-class register-transfer sequencer.
package mov_seq_pkg;

  // Instruction opcodes presented by the decoder.
  typedef enum logic [1:0] {
    OP_MOV  = 2'b00,
    OP_MOVI = 2'b01,
    OP_SWAP = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  // Sequencer states; X1..X3 are the bus-transfer steps.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_X1   = 3'd1,
    S_X2   = 3'd2,
    S_X3   = 3'd3,
    S_FIN  = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  // True when a selector value names an existing register.
  function automatic logic sel_legal(input logic [31:0] sel, input int unsigned n);
    return sel < n;
  endfunction

endpackage

// File: rtl/mov_seq_onehot_dec.sv
// Index-to-one-hot decoder with range flag; oh is all zeros when disabled
// or when the index is past the last register.
module onehot_dec #(
  parameter int N     = 5,
  parameter int SEL_W = 6
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [N-1:0]     oh,
  output logic             valid
);

  logic [31:0] sel_ext;

  assign sel_ext = 32'(sel);
  assign valid   = sel_ext < 32'(N);

  // One compare per output bit.
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign oh[i] = en && (sel_ext == 32'(i));
  end

endmodule

// File: rtl/mov_seq.sv
// Move-class sequencer: turns one MOV/MOVI/SWAP instruction into a short
// series of one-hot register load/drive enables on the shared bus.
// All outputs are decoded from the state register and latched fields, so
// nothing on the input side reaches an output within a cycle.
module mov_seq
  import mov_seq_pkg::*;
#(
  parameter int NUM_REGS = 5,
  parameter int SEL_W    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                donefetch,
  input  logic [1:0]          op,
  input  logic [SEL_W-1:0]    dst_sel,
  input  logic [SEL_W-1:0]    src_sel,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out_en,
  output logic                imm_out_en,
  output logic                tmp_in,
  output logic                tmp_out_en,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [SEL_W-1:0]  dst_q, dst_d;
  logic [SEL_W-1:0]  src_q, src_d;

  logic              issue;
  logic              issue_bad;

  logic              ld_en, dr_en;
  logic [SEL_W-1:0]  ld_sel, dr_sel;
  logic              ld_valid, dr_valid;
  logic              step_ok;

  // An instruction is accepted only from IDLE, and an abort on the same
  // edge wins.
  assign issue = (state_q == S_IDLE) && start && !donefetch;

  // Screen the incoming instruction; MOVI never reads a source register.
  assign issue_bad = (op_e'(op) == OP_RSVD) ||
                     !sel_legal(32'(dst_sel), NUM_REGS) ||
                     ((op_e'(op) != OP_MOVI) && !sel_legal(32'(src_sel), NUM_REGS));

  // Both decoders are always fed a latched index during X1..X3; a range
  // miss there could only come from corrupted fields, so it is routed to ERR.
  assign step_ok = ld_valid && dr_valid;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Latched instruction fields; cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q  <= OP_MOV;
      dst_q <= '0;
      src_q <= '0;
    end else begin
      op_q  <= op_d;
      dst_q <= dst_d;
      src_q <= src_d;
    end
  end

  // Capture the instruction on the accepting edge only.
  always_comb begin
    op_d  = op_q;
    dst_d = dst_q;
    src_d = src_q;
    if (issue) begin
      op_d  = op_e'(op);
      dst_d = dst_sel;
      src_d = src_sel;
    end
  end

  // Next-state: walk the steps for the latched op; abort overrides all.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = issue_bad ? S_ERR : S_X1;
      S_X1:   if (!step_ok)               state_d = S_ERR;
              else if (op_q == OP_SWAP)   state_d = S_X2;
              else                        state_d = S_FIN;
      S_X2:   state_d = step_ok ? S_X3 : S_ERR;
      S_X3:   state_d = step_ok ? S_FIN : S_ERR;
      S_FIN:  state_d = S_IDLE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (donefetch) state_d = S_IDLE;
  end

  // Output decode: pick which latched index feeds each decoder per step.
  always_comb begin
    ld_en      = 1'b0;
    ld_sel     = dst_q;
    dr_en      = 1'b0;
    dr_sel     = dst_q;
    imm_out_en = 1'b0;
    tmp_in     = 1'b0;
    tmp_out_en = 1'b0;
    unique case (state_q)
      S_X1: begin
        // MOV: src->dst, MOVI: imm->dst, SWAP: src->tmp
        ld_en      = (op_q != OP_SWAP);
        ld_sel     = dst_q;
        dr_en      = (op_q != OP_MOVI);
        dr_sel     = (op_q == OP_MOVI) ? dst_q : src_q;
        imm_out_en = (op_q == OP_MOVI);
        tmp_in     = (op_q == OP_SWAP);
      end
      S_X2: begin
        // SWAP: dst->src
        ld_en  = 1'b1;
        ld_sel = src_q;
        dr_en  = 1'b1;
        dr_sel = dst_q;
      end
      S_X3: begin
        // SWAP: tmp->dst
        ld_en      = 1'b1;
        ld_sel     = dst_q;
        tmp_out_en = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_FIN) || (state_q == S_ERR);
  assign err  = (state_q == S_ERR);

  onehot_dec #(.N(NUM_REGS), .SEL_W(SEL_W)) u_ld_dec (
    .sel   (ld_sel),
    .en    (ld_en),
    .oh    (reg_in),
    .valid (ld_valid)
  );

  onehot_dec #(.N(NUM_REGS), .SEL_W(SEL_W)) u_dr_dec (
    .sel   (dr_sel),
    .en    (dr_en),
    .oh    (reg_out_en),
    .valid (dr_valid)
  );

endmodule
